// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch (IF) and load/store (DM) requesters of a multicycle core.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MODE_W = 3,
    parameter logic [MODE_W-1:0] DM_LW = MODE_W'(2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    input  logic [MODE_W-1:0] i_dm_mode,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [MODE_W-1:0] o_mem_mode,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;
    localparam logic       PORT_IF = 1'b0;
    localparam logic       PORT_DM = 1'b1;

    logic [0:0] state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       resp_owner_q, resp_owner_d;

    logic in_idle;
    logic in_resp;
    logic if_gnt;
    logic dm_gnt;

    // Outputs are forced low while rst is asserted, grants included.
    assign in_idle = (state_q == ST_IDLE) && !rst;
    assign in_resp = (state_q == ST_RESP) && !rst;

    // Grant depends only on requests, state and last_gnt.
    assign if_gnt = in_idle && i_if_req && (!i_dm_req || (last_gnt_q == PORT_DM));
    assign dm_gnt = in_idle && i_dm_req && (!i_if_req || (last_gnt_q == PORT_IF));

    assign o_if_gnt    = if_gnt;
    assign o_dm_gnt    = dm_gnt;
    assign o_mem_en    = if_gnt || dm_gnt;
    assign o_mem_we    = dm_gnt && i_dm_we;
    assign o_mem_addr  = if_gnt ? i_if_addr : (dm_gnt ? i_dm_addr : '0);
    assign o_mem_wdata = dm_gnt ? i_dm_wdata : '0;
    assign o_mem_mode  = if_gnt ? DM_LW : (dm_gnt ? i_dm_mode : '0);

    assign o_busy      = in_resp;
    assign o_if_rvalid = in_resp && (resp_owner_q == PORT_IF);
    assign o_dm_rvalid = in_resp && (resp_owner_q == PORT_DM);
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;

    always_comb begin
        state_d      = ST_IDLE;
        last_gnt_d   = last_gnt_q;
        resp_owner_d = resp_owner_q;
        if (if_gnt) begin
            last_gnt_d   = PORT_IF;
            resp_owner_d = PORT_IF;
            state_d      = ST_RESP;
        end else if (dm_gnt) begin
            last_gnt_d = PORT_DM;
            if (!i_dm_we) begin
                resp_owner_d = PORT_DM;
                state_d      = ST_RESP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_gnt_q   <= PORT_DM;
            resp_owner_q <= PORT_IF;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            resp_owner_q <= resp_owner_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge and
// outputs are sampled 1ns later, so each falling edge marks one RAM cycle.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam logic [MW-1:0] LW = 3'b010;
    localparam logic [MW-1:0] SB = 3'b000;
    localparam logic [MW-1:0] SH = 3'b001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [MW-1:0] dm_mode = '0;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_mode;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MODE_W(MW)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .i_dm_mode(dm_mode),
        .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_mode(mem_mode),
        .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    // Control flags packed as {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, busy}.
    logic [6:0] ctl;
    assign ctl = {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, busy};

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_addr = 32'h88;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        n_checks++;
        if (ctl !== 7'b0) begin n_fail++; $display("FAIL reset_ctl actual=%b required=%b", ctl, 7'b0); end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_mode, if_rdata, dm_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data addr=%h wdata=%h mode=%h if_rdata=%h dm_rdata=%h required=0",
                               mem_addr, mem_wdata, mem_mode, if_rdata, dm_rdata);
        end
        if_req = 1'b0; dm_req = 1'b0; mem_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hDEAD_BEEF; #1;
        n_checks++;
        if (ctl !== 7'b1010000) begin n_fail++; $display("FAIL if_read_grant ctl actual=%b required=%b", ctl, 7'b1010000); end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_mode} !== {32'h100, 32'h0, LW}) begin
            n_fail++; $display("FAIL if_read_bus addr=%h wdata=%h mode=%h required addr=100 wdata=0 mode=%h",
                               mem_addr, mem_wdata, mem_mode, LW);
        end
        @(negedge clk);
        if_req = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b0000101) begin n_fail++; $display("FAIL if_read_resp ctl actual=%b required=%b", ctl, 7'b0000101); end
        n_checks++;
        if ({if_rdata, dm_rdata} !== {32'hDEAD_BEEF, 32'h0}) begin
            n_fail++; $display("FAIL if_read_rdata if=%h dm=%h required if=deadbeef dm=0", if_rdata, dm_rdata);
        end
        @(negedge clk); #1;
        n_checks++;
        if (ctl !== 7'b0 || if_rdata !== 32'h0) begin
            n_fail++; $display("FAIL if_read_after ctl=%b if_rdata=%h required ctl=0 rdata=0", ctl, if_rdata);
        end
        $display("txn IF read 0x100 -> %h", 32'hDEAD_BEEF);
    endtask

    // Runs right after an IF grant, so DM wins the tie.
    task automatic test_dm_read_contention();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_mode = LW; dm_wdata = 32'h1111_2222; #1;
        n_checks++;
        if (ctl !== 7'b0110000 || mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL contention_dm_grant ctl=%b addr=%h required ctl=0110000 addr=80", ctl, mem_addr);
        end
        n_checks++;
        if (mem_wdata !== 32'h1111_2222 || mem_mode !== LW) begin
            n_fail++; $display("FAIL contention_dm_bus wdata=%h mode=%h required wdata=11112222 mode=%h", mem_wdata, mem_mode, LW);
        end
        @(negedge clk);
        dm_req = 1'b0; mem_rdata = 32'h55AA_1234; #1;
        n_checks++;
        if (ctl !== 7'b0000011) begin n_fail++; $display("FAIL contention_resp ctl actual=%b required=%b", ctl, 7'b0000011); end
        n_checks++;
        if ({dm_rdata, if_rdata} !== {32'h55AA_1234, 32'h0}) begin
            n_fail++; $display("FAIL contention_rdata dm=%h if=%h required dm=55aa1234 if=0", dm_rdata, if_rdata);
        end
        @(negedge clk); #1;
        n_checks++;
        if (ctl !== 7'b1010000 || mem_addr !== 32'h300 || dm_rdata !== 32'h0) begin
            n_fail++; $display("FAIL contention_if_grant ctl=%b addr=%h dm_rdata=%h required ctl=1010000 addr=300 rdata=0",
                               ctl, mem_addr, dm_rdata);
        end
        @(negedge clk);
        if_req = 1'b0; mem_rdata = 32'h0BAD_F00D; #1;
        n_checks++;
        if (ctl !== 7'b0000101 || if_rdata !== 32'h0BAD_F00D || dm_rdata !== 32'h0) begin
            n_fail++; $display("FAIL contention_if_resp ctl=%b if_rdata=%h dm_rdata=%h required ctl=0000101 if=0badf00d dm=0",
                               ctl, if_rdata, dm_rdata);
        end
        @(negedge clk);
        $display("txn DM read 0x80 then IF read 0x300");
    endtask

    task automatic test_back_to_back_writes();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h1234_5678; dm_mode = SB; #1;
        n_checks++;
        if (ctl !== 7'b0111000 || {mem_addr, mem_wdata, mem_mode} !== {32'h200, 32'h1234_5678, SB}) begin
            n_fail++; $display("FAIL write1 ctl=%b addr=%h wdata=%h mode=%h required ctl=0111000 addr=200 wdata=12345678 mode=%h",
                               ctl, mem_addr, mem_wdata, mem_mode, SB);
        end
        @(negedge clk);
        dm_addr = 32'h204; dm_wdata = 32'hCAFE_F00D; dm_mode = SH; #1;
        n_checks++;
        if (ctl !== 7'b0111000 || {mem_addr, mem_wdata, mem_mode} !== {32'h204, 32'hCAFE_F00D, SH}) begin
            n_fail++; $display("FAIL write2 ctl=%b addr=%h wdata=%h mode=%h required ctl=0111000 addr=204 wdata=cafef00d mode=%h",
                               ctl, mem_addr, mem_wdata, mem_mode, SH);
        end
        @(negedge clk);
        dm_req = 1'b0; dm_we = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b0) begin n_fail++; $display("FAIL write_after ctl actual=%b required=%b", ctl, 7'b0); end
        $display("txn DM writes 0x200, 0x204");
    endtask

    task automatic test_fairness();
        logic [6:0] exp_ctl [6];
        logic [AW-1:0] exp_addr [6];
        exp_ctl[0] = 7'b1010000; exp_addr[0] = 32'h0;
        exp_ctl[1] = 7'b0000101; exp_addr[1] = 32'h0;
        exp_ctl[2] = 7'b0110000; exp_addr[2] = 32'h40;
        exp_ctl[3] = 7'b0000011; exp_addr[3] = 32'h0;
        exp_ctl[4] = 7'b1010000; exp_addr[4] = 32'h0;
        exp_ctl[5] = 7'b0000101; exp_addr[5] = 32'h0;
        @(negedge clk);
        rst = 1'b1; #1;
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_mode = LW;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            mem_rdata = 32'hA000_0000 + c;
            #1;
            n_checks++;
            if (ctl !== exp_ctl[c] || mem_addr !== exp_addr[c]) begin
                n_fail++; $display("FAIL fair_cycle%0d ctl=%b addr=%h required ctl=%b addr=%h",
                                   c, ctl, mem_addr, exp_ctl[c], exp_addr[c]);
            end
            if (c % 2 == 1) begin
                n_checks++;
                if ((if_rdata | dm_rdata) !== (32'hA000_0000 + c)) begin
                    n_fail++; $display("FAIL fair_rdata%0d if=%h dm=%h required=%h", c, if_rdata, dm_rdata, 32'hA000_0000 + c);
                end
            end
            $display("txn fairness cycle %0d ctl=%b", c, ctl);
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_resp();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h7777_7777; #1;
        n_checks++;
        if (ctl !== 7'b1010000) begin n_fail++; $display("FAIL midrst_grant ctl actual=%b required=%b", ctl, 7'b1010000); end
        @(negedge clk);
        rst = 1'b1; dm_req = 1'b1; dm_addr = 32'h20; dm_we = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b0 || if_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL midrst_outputs ctl=%b if_rdata=%h addr=%h required all 0", ctl, if_rdata, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0; #1;
        n_checks++;
        if (ctl !== 7'b1010000 || mem_addr !== 32'h10) begin
            n_fail++; $display("FAIL midrst_first_tie ctl=%b addr=%h required ctl=1010000 addr=10", ctl, mem_addr);
        end
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0; #1;
        @(negedge clk);
        $display("txn reset during RESP");
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (ctl !== 7'b0 || {mem_addr, mem_wdata, mem_mode} !== '0) begin
                n_fail++; $display("FAIL idle_cycle%0d ctl=%b addr=%h wdata=%h mode=%h required all 0",
                                   c, ctl, mem_addr, mem_wdata, mem_mode);
            end
        end
        $display("txn idle 10 cycles");
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_read_contention();
        test_back_to_back_writes();
        test_fairness();
        test_reset_mid_resp();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
